// File: rtl/kernel_arbiter.sv
// Round-robin arbiter sharing one convolution kernel engine among NUM_REQ requesters.
// Latches the winner's operands and sequences engine start, result capture, clear and done.
module kernel_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int MAX_KERNEL = 3,
    parameter int TIMEOUT    = 64
) (
    input  logic                                                   clk,
    input  logic                                                   n_rst,
    input  logic [NUM_REQ-1:0]                                     req,
    input  logic [NUM_REQ-1:0][MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] req_matrix,
    input  logic [NUM_REQ-1:0][MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] req_kernel,
    input  logic [NUM_REQ-1:0][$clog2(MAX_KERNEL)-1:0]             req_kernel_size,
    output logic [NUM_REQ-1:0]                                     grant,
    output logic [NUM_REQ-1:0]                                     resp_valid,
    output logic [7:0]                                             resp_pixel,
    output logic                                                   resp_err,
    output logic                                                   busy,
    output logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]             eng_matrix,
    output logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]             eng_kernel,
    output logic [$clog2(MAX_KERNEL)-1:0]                          eng_kernel_size,
    output logic                                                   eng_start,
    output logic                                                   eng_clear,
    input  logic                                                   eng_clear_signal,
    input  logic                                                   eng_clear_flag,
    input  logic                                                   eng_done,
    input  logic [7:0]                                             eng_pixel
);

    localparam int OW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW   = OW + 1;
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_RESULT,
        CLEAR,
        WAIT_DONE,
        RESPOND
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [OW-1:0]   ptr;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   winner;
    logic            found;
    logic [SW-1:0]   cand;
    logic [7:0]      result;
    logic            err;
    logic [WD_W-1:0] wd_cnt;
    logic            waiting;
    logic            advance;
    logic            wd_hit;
    logic            timeout_fire;

    // Search upward from ptr, wrapping at NUM_REQ; the first asserted request wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + SW'(i);
            if (cand >= SW'(NUM_REQ)) begin
                cand = cand - SW'(NUM_REQ);
            end
            if (!found && req[cand[OW-1:0]]) begin
                found  = 1'b1;
                winner = cand[OW-1:0];
            end
        end
    end

    // The watchdog fires on the cycle its count would reach TIMEOUT-1, unless the
    // engine advances in that same cycle.
    always_comb begin
        waiting      = (state == WAIT_RESULT) || (state == CLEAR) || (state == WAIT_DONE);
        advance      = ((state == WAIT_RESULT) && eng_clear_signal) ||
                       ((state == CLEAR)       && eng_clear_flag)   ||
                       ((state == WAIT_DONE)   && eng_done);
        wd_hit       = (wd_cnt == WD_W'(TIMEOUT - 2));
        timeout_fire = waiting && wd_hit && !advance;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:        if (found) next_state = LAUNCH;
            LAUNCH:      next_state = WAIT_RESULT;
            WAIT_RESULT: begin
                if (eng_clear_signal)  next_state = CLEAR;
                else if (timeout_fire) next_state = RESPOND;
            end
            CLEAR: begin
                if (eng_clear_flag)    next_state = WAIT_DONE;
                else if (timeout_fire) next_state = RESPOND;
            end
            WAIT_DONE: begin
                if (eng_done || timeout_fire) next_state = RESPOND;
            end
            RESPOND:     next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // Operand latch, arbitration pointer, result capture and watchdog.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr             <= '0;
            owner           <= '0;
            result          <= '0;
            err             <= 1'b0;
            wd_cnt          <= '0;
            eng_matrix      <= '0;
            eng_kernel      <= '0;
            eng_kernel_size <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        eng_matrix      <= req_matrix[winner];
                        eng_kernel      <= req_kernel[winner];
                        eng_kernel_size <= req_kernel_size[winner];
                        owner           <= winner;
                        ptr             <= (winner == OW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                        result          <= '0;
                        err             <= 1'b0;
                    end
                end
                LAUNCH: begin
                    wd_cnt <= '0;
                end
                WAIT_RESULT, CLEAR, WAIT_DONE: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if ((state == WAIT_RESULT) && eng_clear_signal) begin
                        result <= eng_pixel;
                    end
                    if (timeout_fire) begin
                        result <= '0;
                        err    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        grant      = '0;
        resp_valid = '0;
        resp_pixel = '0;
        resp_err   = 1'b0;
        eng_start  = 1'b0;
        eng_clear  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            LAUNCH: begin
                grant[owner] = 1'b1;
                eng_start    = 1'b1;
            end
            CLEAR: begin
                eng_clear = 1'b1;
            end
            RESPOND: begin
                resp_valid[owner] = 1'b1;
                resp_pixel        = result;
                resp_err          = err;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_kernel_arbiter.sv
// Directed self-checking bench for kernel_arbiter; the engine handshake is driven by hand.
module tb_kernel_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int MAX_KERNEL = 3;
    localparam int TIMEOUT    = 64;

    logic                                                   clk;
    logic                                                   n_rst;
    logic [NUM_REQ-1:0]                                     req;
    logic [NUM_REQ-1:0][MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] req_matrix;
    logic [NUM_REQ-1:0][MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] req_kernel;
    logic [NUM_REQ-1:0][1:0]                                req_kernel_size;
    logic [NUM_REQ-1:0]                                     grant;
    logic [NUM_REQ-1:0]                                     resp_valid;
    logic [7:0]                                             resp_pixel;
    logic                                                   resp_err;
    logic                                                   busy;
    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]             eng_matrix;
    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]             eng_kernel;
    logic [1:0]                                             eng_kernel_size;
    logic                                                   eng_start;
    logic                                                   eng_clear;
    logic                                                   eng_clear_signal;
    logic                                                   eng_clear_flag;
    logic                                                   eng_done;
    logic [7:0]                                             eng_pixel;

    int checks = 0;
    int errors = 0;

    localparam logic [71:0] ONES_WIN = {9{8'h01}};
    localparam logic [71:0] PAT_A    = 72'h18_17_16_15_14_13_12_11_10;
    localparam logic [71:0] PAT_B    = 72'hE8_E7_E6_E5_E4_E3_E2_E1_E0;

    kernel_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .MAX_KERNEL(MAX_KERNEL),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .req             (req),
        .req_matrix      (req_matrix),
        .req_kernel      (req_kernel),
        .req_kernel_size (req_kernel_size),
        .grant           (grant),
        .resp_valid      (resp_valid),
        .resp_pixel      (resp_pixel),
        .resp_err        (resp_err),
        .busy            (busy),
        .eng_matrix      (eng_matrix),
        .eng_kernel      (eng_kernel),
        .eng_kernel_size (eng_kernel_size),
        .eng_start       (eng_start),
        .eng_clear       (eng_clear),
        .eng_clear_signal(eng_clear_signal),
        .eng_clear_flag  (eng_clear_flag),
        .eng_done        (eng_done),
        .eng_pixel       (eng_pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_grant"},      72'(grant),      72'(0));
        check_output({tag, "_resp_valid"}, 72'(resp_valid), 72'(0));
        check_output({tag, "_resp_pixel"}, 72'(resp_pixel), 72'(0));
        check_output({tag, "_resp_err"},   72'(resp_err),   72'(0));
        check_output({tag, "_busy"},       72'(busy),       72'(0));
        check_output({tag, "_eng_start"},  72'(eng_start),  72'(0));
        check_output({tag, "_eng_clear"},  72'(eng_clear),  72'(0));
        check_output({tag, "_eng_matrix"}, eng_matrix,      72'(0));
        check_output({tag, "_eng_kernel"}, eng_kernel,      72'(0));
        check_output({tag, "_eng_ksize"},  72'(eng_kernel_size), 72'(0));
    endtask

    // One complete job from IDLE: grant to `who`, engine yields `pix`, req becomes `req_after`.
    task automatic apply_stimulus(input int who, input logic [7:0] pix, input logic [1:0] req_after);
        step();
        check_output("job_grant", 72'(grant), 72'(1) << who);
        check_output("job_start", 72'(eng_start), 72'(1));
        req              = req_after;
        eng_clear_signal = 1'b1;
        eng_pixel        = pix;
        step();
        step();
        check_output("job_clear", 72'(eng_clear), 72'(1));
        eng_clear_signal = 1'b0;
        eng_pixel        = 8'h00;
        eng_clear_flag   = 1'b1;
        step();
        eng_clear_flag = 1'b0;
        eng_done       = 1'b1;
        step();
        check_output("job_resp_valid", 72'(resp_valid), 72'(1) << who);
        check_output("job_resp_pixel", 72'(resp_pixel), 72'(pix));
        check_output("job_resp_err",   72'(resp_err),   72'(0));
        eng_done = 1'b0;
        step();
    endtask

    task automatic pulse_reset();
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        step();
    endtask

    initial begin
        n_rst            = 1'b0;
        req              = '0;
        req_matrix       = '0;
        req_kernel       = '0;
        req_kernel_size  = '0;
        eng_clear_signal = 1'b0;
        eng_clear_flag   = 1'b0;
        eng_done         = 1'b0;
        eng_pixel        = 8'h00;

        #2;
        check_all_zero("reset");
        step();
        n_rst = 1'b1;
        step();

        $display("[TB] single request");
        req_matrix[0]      = ONES_WIN;
        req_kernel[0]      = ONES_WIN;
        req_kernel_size[0] = 2'd3;
        req                = 2'b01;
        check_output("idle_grant", 72'(grant), 72'(0));
        apply_stimulus(0, 8'h5A, 2'b00);
        check_output("single_busy",   72'(busy),            72'(0));
        check_output("single_matrix", eng_matrix,           ONES_WIN);
        check_output("single_kernel", eng_kernel,           ONES_WIN);
        check_output("single_ksize",  72'(eng_kernel_size), 72'(3));

        $display("[TB] simultaneous requests");
        pulse_reset();
        req = 2'b11;
        apply_stimulus(0, 8'h10, 2'b11);
        apply_stimulus(1, 8'h21, 2'b11);
        apply_stimulus(0, 8'h32, 2'b11);
        apply_stimulus(1, 8'h43, 2'b11);
        apply_stimulus(0, 8'h54, 2'b11);
        apply_stimulus(1, 8'h65, 2'b00);

        $display("[TB] operand isolation");
        req_matrix[0]      = PAT_A;
        req_kernel_size[0] = 2'd2;
        req                = 2'b01;
        step();
        check_output("iso_grant", 72'(grant), 72'(1));
        req                = 2'b00;
        req_matrix[0]      = PAT_B;
        req_kernel_size[0] = 2'd1;
        eng_clear_signal   = 1'b1;
        eng_pixel          = 8'h42;
        step();
        step();
        check_output("iso_matrix_clear", eng_matrix, PAT_A);
        eng_clear_signal = 1'b0;
        eng_clear_flag   = 1'b1;
        step();
        eng_clear_flag = 1'b0;
        eng_done       = 1'b1;
        step();
        check_output("iso_resp_valid",    72'(resp_valid),      72'(1));
        check_output("iso_resp_pixel",    72'(resp_pixel),      72'(8'h42));
        check_output("iso_matrix_resp",   eng_matrix,           PAT_A);
        check_output("iso_ksize_resp",    72'(eng_kernel_size), 72'(2));
        eng_done = 1'b0;
        step();

        $display("[TB] timeout");
        req            = 2'b01;
        eng_done       = 1'b1;
        eng_clear_flag = 1'b1;
        eng_pixel      = 8'h77;
        step();
        check_output("to_grant", 72'(grant), 72'(1));
        req = 2'b00;
        for (int i = 1; i < TIMEOUT; i++) begin
            step();
        end
        check_output("to_early_valid", 72'(resp_valid), 72'(0));
        check_output("to_early_busy",  72'(busy),       72'(1));
        step();
        check_output("to_resp_valid", 72'(resp_valid), 72'(1));
        check_output("to_resp_err",   72'(resp_err),   72'(1));
        check_output("to_resp_pixel", 72'(resp_pixel), 72'(0));
        eng_done       = 1'b0;
        eng_clear_flag = 1'b0;
        step();
        check_output("to_idle_busy", 72'(busy), 72'(0));
        req = 2'b10;
        apply_stimulus(1, 8'h33, 2'b00);

        $display("[TB] clear handshake stall");
        req = 2'b01;
        step();
        check_output("stall_grant", 72'(grant), 72'(1));
        req              = 2'b00;
        eng_clear_signal = 1'b1;
        eng_pixel        = 8'hC3;
        step();
        step();
        eng_clear_signal = 1'b0;
        eng_pixel        = 8'h11;
        for (int i = 0; i < 10; i++) begin
            check_output("stall_clear_high", 72'(eng_clear), 72'(1));
            step();
        end
        eng_clear_flag = 1'b1;
        check_output("stall_clear_flag_cycle", 72'(eng_clear), 72'(1));
        step();
        check_output("stall_clear_dropped", 72'(eng_clear), 72'(0));
        eng_clear_flag = 1'b0;
        eng_done       = 1'b1;
        step();
        check_output("stall_resp_valid", 72'(resp_valid), 72'(1));
        check_output("stall_resp_pixel", 72'(resp_pixel), 72'(8'hC3));
        check_output("stall_resp_err",   72'(resp_err),   72'(0));
        eng_done = 1'b0;
        step();

        $display("[TB] reset mid-job");
        req_matrix[0] = PAT_A;
        req           = 2'b01;
        step();
        req              = 2'b00;
        eng_clear_signal = 1'b1;
        eng_pixel        = 8'h99;
        step();
        step();
        eng_clear_signal = 1'b0;
        eng_clear_flag   = 1'b1;
        step();
        eng_clear_flag = 1'b0;
        check_output("mid_busy_wait_done", 72'(busy), 72'(1));
        check_output("mid_matrix_before",  eng_matrix, PAT_A);
        eng_done = 1'b1;
        n_rst    = 1'b0;
        #1;
        check_all_zero("mid_reset");
        step();
        check_output("mid_no_resp_in_reset", 72'(resp_valid), 72'(0));
        eng_done = 1'b0;
        n_rst    = 1'b1;
        step();
        check_output("mid_no_resp_after", 72'(resp_valid), 72'(0));
        check_output("mid_idle_busy",     72'(busy),       72'(0));
        req = 2'b10;
        apply_stimulus(1, 8'h5C, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kernel_arbiter.md
# kernel_arbiter

Round-robin scheduler that shares one convolution kernel engine between `NUM_REQ` pixel-producing requesters (e.g. blur and corner-score pipelines). It latches the winning requester's window, kernel and kernel size, and sequences the engine through start, result capture, accumulator clear and done. It returns the result, or a timeout error, to the owning requester. It sits between the image-walk front ends and the single compute engine instance.

## Interface
- `NUM_REQ`, 2: number of requesters (≥2).
- `MAX_KERNEL`, 3: window/kernel dimension; matches the engine.
- `TIMEOUT`, 64: watchdog limit in cycles from launch to engine done.

- `clk` in 1: single clock, rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `req` in `NUM_REQ`: request level per requester; held until its `grant`.
- `req_matrix` in `NUM_REQ`×`MAX_KERNEL`×`MAX_KERNEL`×8: pixel windows.
- `req_kernel` in `NUM_REQ`×`MAX_KERNEL`×`MAX_KERNEL`×8: kernels.
- `req_kernel_size` in `NUM_REQ`×`$clog2(MAX_KERNEL)`: per-requester kernel size.
- `grant` out `NUM_REQ`: one-cycle one-hot pulse; operands captured.
- `resp_valid` out `NUM_REQ`: one-cycle one-hot pulse to the owner.
- `resp_pixel` out 8: result, valid with `resp_valid`.
- `resp_err` out 1: timeout flag, valid with `resp_valid`.
- `busy` out 1: high whenever state ≠ IDLE.
- `eng_matrix`, `eng_kernel`, `eng_kernel_size` out: latched operands to the engine.
- `eng_start` out 1: one-cycle start pulse.
- `eng_clear` out 1: accumulator clear request.
- `eng_clear_signal` in 1: engine is in its complete state and the result is stable.
- `eng_clear_flag` in 1: engine acknowledges the clear.
- `eng_done` in 1: engine job finished.
- `eng_pixel` in 8: engine accumulator output.

## Operation
- States: IDLE, LAUNCH, WAIT_RESULT, CLEAR, WAIT_DONE, RESPOND.
- IDLE: if any `req`, the winner is the first asserted bit searching upward from pointer `ptr`, modulo `NUM_REQ`.
  - At the clock edge, latch the winner's operands into `eng_*` registers and store `owner`.
  - Set `ptr` = (winner+1) mod `NUM_REQ` and go to LAUNCH.
- LAUNCH: `grant[owner]`=1 and `eng_start`=1 for this single cycle; clear the watchdog; go to WAIT_RESULT.
- WAIT_RESULT: when `eng_clear_signal`=1, capture `eng_pixel` into `result` and go to CLEAR.
- CLEAR: `eng_clear`=1, held until `eng_clear_flag`=1 is sampled, then go to WAIT_DONE. `eng_clear` drops in WAIT_DONE.
- WAIT_DONE: on `eng_done`=1, go to RESPOND.
- RESPOND: `resp_valid[owner]`=1, `resp_pixel`=`result`, `resp_err`=error bit; go to IDLE.
- Watchdog: counts every cycle in WAIT_RESULT, CLEAR and WAIT_DONE. On reaching `TIMEOUT`-1 from any of these states:
  - go to RESPOND with `resp_err`=1 and `resp_pixel`=0;
  - deassert `eng_clear`.
- Operands are stable from LAUNCH through RESPOND; requester inputs are ignored after the grant.
- A `req` still high in the cycle after RESPOND counts as a new request.
- Requests from non-owners are never dropped; they are held and served in round-robin order.
- Boundary behaviour:
  - `ptr` wraps from `NUM_REQ`-1 to 0.
  - `eng_done` outside WAIT_DONE is ignored.
  - `eng_clear_signal` outside WAIT_RESULT is ignored.
  - If the timeout and the advancing event fall in the same cycle, the advancing event wins.

## Timing
- Reset: state IDLE, `ptr`=0, `owner`=0, `result`=0, watchdog=0. All outputs, including the `eng_*` operand registers, are 0.
- Reset mid-job aborts immediately; no response is issued. The engine shares `n_rst`.
- `req` sampled high in IDLE at edge k gives `grant` and `eng_start` high in cycle k+1.
- Response: `resp_valid` is high the cycle after `eng_done` is sampled.
- Overhead beyond engine latency: 3 cycles (LAUNCH, WAIT_DONE exit, RESPOND).
- Back-to-back: the next grant comes no earlier than 2 cycles after `resp_valid` (IDLE, then LAUNCH).
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

## Test plan
- Single request: `req`=01, all-ones window and kernel, size 3, engine model yields 0x5A.
  - Expect `grant`=01 for one cycle, `eng_start` the same cycle, one `eng_clear` handshake.
  - Expect `resp_valid`=01 with `resp_pixel`=0x5A, `resp_err`=0, and `busy` low again after RESPOND.
- Simultaneous requests: `req`=11 from reset gives grant order 0,1.
  - With both held continuously for 6 jobs, grants alternate 0,1,0,1,0,1.
  - Each response goes only to its owner.
- Operand isolation: requester 0 changes `req_matrix` the cycle after grant.
  - `eng_matrix` keeps the granted value through RESPOND.
  - `eng_kernel_size` equals the granted size (2).
- Timeout: engine model never raises `eng_clear_signal`.
  - Expect `resp_valid` with `resp_err`=1 and `resp_pixel`=0 exactly `TIMEOUT` cycles after LAUNCH.
  - The next request is granted normally.
- Clear handshake stall: engine holds `eng_clear_flag` low for 10 cycles.
  - `eng_clear` stays high for all 10 cycles and drops after the flag.
  - Result equals the value captured at `eng_clear_signal`.
- Reset mid-job: assert `n_rst` low during WAIT_DONE.
  - All outputs are 0 asynchronously and no `resp_valid` is issued.
  - After release, `req`=10 is granted to requester 1 with `ptr` restarted at 0.
